// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Fetches one instruction at a time from an instruction memory. For each
// fetch it issues a single request, waits for the response, and holds the
// word until decode accepts it. ECALL/EBREAK end the program, and a
// misaligned PC or (optionally) an unanswered request raises a sticky fault.
//
// Optional feature:
//   IFETCH_TIMEOUT_EN - when defined, a watchdog aborts with fault=10 after
//                       TIMEOUT_CYCLES cycles in WAIT with no response.
//                       When undefined, WAIT lasts until imem_valid.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit in cycles (2..255), default 16
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous, active-low reset
//   pc_reg       in   32  current PC from the PC stage
//   imem_req     out  1   one-cycle fetch request pulse
//   imem_addr    out  30  word address (pc_reg[31:2]); holds when idle
//   imem_valid   in   1   memory response strobe (honoured only in WAIT)
//   imem_rdata   in   32  instruction word
//   instr        out  32  fetched instruction
//   instr_pc     out  32  PC of instr
//   instr_valid  out  1   instr/instr_pc valid
//   instr_ready  in   1   decode accepts (handshake = instr_valid & instr_ready)
//   pc_advance   out  1   one-cycle pulse: PC stage steps by 4
//   finish_flag  out  1   sticky program-end / fault indication
//   fault        out  2   00 none, 01 misaligned PC, 10 imem timeout
//   fetch_count  out  32  completed handshakes, saturating
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_reg,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        pc_advance,
  output logic        finish_flag,
  output logic [1:0]  fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_TIMEOUT  = 2'b10;
  localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;

  state_t      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_pc_advance;
  logic        r_finish;
  logic [1:0]  r_fault;
  logic [31:0] r_count;
  logic [29:0] r_addr;

  logic        w_aligned;
  logic        w_handshake;
  logic        w_is_stop;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wdog;
`else
  // Parameter kept for a uniform interface; it has no effect in this build.
  logic [7:0] w_unused_tmo;
  assign w_unused_tmo = 8'(TIMEOUT_CYCLES);
`endif

  assign w_aligned   = (pc_reg[1:0] == 2'b00);
  assign w_handshake = r_instr_valid & instr_ready;
  assign w_is_stop   = (r_instr == INSTR_ECALL) || (r_instr == INSTR_EBREAK);

  // The request must appear in the same REQ cycle in which pc_reg is checked,
  // so imem_req and the address are decoded from state; the address register
  // only remembers the last issued address for the idle periods.
  assign imem_req  = (r_state == S_REQ) && w_aligned;
  assign imem_addr = imem_req ? pc_reg[31:2] : r_addr;

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign pc_advance  = r_pc_advance;
  assign finish_flag = r_finish;
  assign fault       = r_fault;
  assign fetch_count = r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_pc_advance  <= 1'b0;
      r_finish      <= 1'b0;
      r_fault       <= FAULT_NONE;
      r_count       <= '0;
      r_addr        <= '0;
`ifdef IFETCH_TIMEOUT_EN
      r_wdog        <= '0;
`endif
    end else begin
      r_pc_advance <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end

        S_REQ: begin
          if (!w_aligned) begin
            r_fault  <= FAULT_MISALIGN;
            r_finish <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_instr_pc <= pc_reg;
            r_addr     <= pc_reg[31:2];
`ifdef IFETCH_TIMEOUT_EN
            r_wdog     <= '0;
`endif
            r_state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_valid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (r_wdog == WDOG_LAST) begin
            r_fault  <= FAULT_TIMEOUT;
            r_finish <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
`endif
        end

        S_HOLD: begin
          if (w_handshake) begin
            r_instr_valid <= 1'b0;
            if (r_count != '1) begin
              r_count <= r_count + 32'd1;
            end
            // A stop instruction ends the program: the PC must not step,
            // and DONE keeps pc_advance low from its first cycle.
            if (w_is_stop) begin
              r_finish <= 1'b1;
              r_fault  <= FAULT_NONE;
              r_state  <= S_DONE;
            end else begin
              r_pc_advance <= 1'b1;
              r_state      <= S_REQ;
            end
          end
        end

        S_DONE: begin
          r_state <= S_DONE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. Inputs change 1 ns after the rising edge,
// outputs are sampled at the same point. Build with +define+IFETCH_TIMEOUT_EN
// to exercise the watchdog; TIMEOUT_CYCLES is overridden to 4.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc_reg;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_advance;
  logic        finish_flag;
  logic [1:0]  fault;
  logic [31:0] fetch_count;

  int unsigned n_total;
  int unsigned n_bad;

  instr_fetch #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_reg      (pc_reg),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_advance  (pc_advance),
    .finish_flag (finish_flag),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [31:0] pc);
    reset       = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    pc_reg      = pc;
    tick();
    tick();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;

    // ---- reset values --------------------------------------------------
    apply_reset(32'h0000_0000);
    check("rst_req",    {31'd0, imem_req},    32'd0);
    check("rst_addr",   {2'd0, imem_addr},    32'd0);
    check("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr",  instr,                32'd0);
    check("rst_ipc",    instr_pc,             32'd0);
    check("rst_adv",    {31'd0, pc_advance},  32'd0);
    check("rst_fin",    {31'd0, finish_flag}, 32'd0);
    check("rst_fault",  {30'd0, fault},       32'd0);
    check("rst_cnt",    fetch_count,          32'd0);

    // ---- basic fetch, then stall with instr_ready low -----------------
    reset = 1'b1;
    tick();                                   // IDLE -> REQ
    check("f1_req",  {31'd0, imem_req}, 32'd1);
    check("f1_addr", {2'd0, imem_addr}, 32'd0);
    imem_valid = 1'b1;                        // ignored in REQ
    imem_rdata = 32'h0050_0093;
    tick();                                   // REQ -> WAIT
    check("f1_req_low", {31'd0, imem_req},    32'd0);
    check("f1_iv_wait", {31'd0, instr_valid}, 32'd0);
    tick();                                   // WAIT -> HOLD
    imem_valid = 1'b0;
    check("f1_iv",    {31'd0, instr_valid}, 32'd1);
    check("f1_instr", instr,                32'h0050_0093);
    check("f1_ipc",   instr_pc,             32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_iv",    {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr,                32'h0050_0093);
      check("stall_ipc",   instr_pc,             32'd0);
      check("stall_adv",   {31'd0, pc_advance},  32'd0);
      check("stall_req",   {31'd0, imem_req},    32'd0);
    end
    instr_ready = 1'b1;
    pc_reg      = 32'h0000_0004;
    tick();                                   // handshake -> REQ
    instr_ready = 1'b0;
    check("hs_iv",   {31'd0, instr_valid}, 32'd0);
    check("hs_adv",  {31'd0, pc_advance},  32'd1);
    check("hs_cnt",  fetch_count,          32'd1);
    check("f2_req",  {31'd0, imem_req},    32'd1);
    check("f2_addr", {2'd0, imem_addr},    32'd1);
    tick();                                   // REQ -> WAIT
    check("f2_adv_low", {31'd0, pc_advance}, 32'd0);
    check("f2_addr_hold", {2'd0, imem_addr}, 32'd1);
    check("f2_req_low", {31'd0, imem_req},   32'd0);

`ifdef IFETCH_TIMEOUT_EN
    // ---- watchdog: 4 WAIT cycles without response ---------------------
    tick();
    tick();
    tick();                                   // 4th WAIT cycle now
    check("to_fin_early", {31'd0, finish_flag}, 32'd0);
    tick();                                   // -> DONE
    check("to_fin",   {31'd0, finish_flag}, 32'd1);
    check("to_fault", {30'd0, fault},       32'd2);
    check("to_req",   {31'd0, imem_req},    32'd0);
    check("to_cnt",   fetch_count,          32'd1);
`else
    // ---- no watchdog: still waiting after 100 cycles ------------------
    for (int i = 0; i < 100; i++) tick();
    check("nw_fin",   {31'd0, finish_flag}, 32'd0);
    check("nw_fault", {30'd0, fault},       32'd0);
    check("nw_iv",    {31'd0, instr_valid}, 32'd0);
    check("nw_req",   {31'd0, imem_req},    32'd0);
    imem_valid = 1'b1;
    imem_rdata = 32'h0010_0073;               // EBREAK
    tick();                                   // WAIT -> HOLD
    imem_valid = 1'b0;
    check("nw_late_iv",    {31'd0, instr_valid}, 32'd1);
    check("nw_late_instr", instr,                32'h0010_0073);
    check("nw_late_ipc",   instr_pc,             32'h0000_0004);
    instr_ready = 1'b1;
    tick();                                   // handshake -> DONE
    instr_ready = 1'b0;
    check("eb_fin",   {31'd0, finish_flag}, 32'd1);
    check("eb_fault", {30'd0, fault},       32'd0);
    check("eb_cnt",   fetch_count,          32'd2);
    check("eb_adv",   {31'd0, pc_advance},  32'd0);
`endif

    // ---- ECALL ends the program ---------------------------------------
    apply_reset(32'h0000_0010);
    reset = 1'b1;
    tick();                                   // REQ
    check("ec_req",  {31'd0, imem_req}, 32'd1);
    check("ec_addr", {2'd0, imem_addr}, 32'd4);
    tick();                                   // WAIT
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0073;
    tick();                                   // HOLD
    imem_valid  = 1'b0;
    instr_ready = 1'b1;
    tick();                                   // handshake -> DONE
    instr_ready = 1'b0;
    check("ec_fin",   {31'd0, finish_flag}, 32'd1);
    check("ec_fault", {30'd0, fault},       32'd0);
    check("ec_cnt",   fetch_count,          32'd1);
    check("ec_iv",    {31'd0, instr_valid}, 32'd0);
    check("ec_adv",   {31'd0, pc_advance},  32'd0);
    imem_valid = 1'b1;                        // must be ignored in DONE
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ec_done_req", {31'd0, imem_req},    32'd0);
      check("ec_done_fin", {31'd0, finish_flag}, 32'd1);
      check("ec_done_iv",  {31'd0, instr_valid}, 32'd0);
      check("ec_done_cnt", fetch_count,          32'd1);
    end
    imem_valid = 1'b0;

    // ---- misaligned PC ------------------------------------------------
    apply_reset(32'h0000_0006);
    reset = 1'b1;
    tick();                                   // REQ, misaligned
    check("mis_req", {31'd0, imem_req},    32'd0);
    check("mis_fin0", {31'd0, finish_flag}, 32'd0);
    tick();                                   // -> DONE
    check("mis_fin",   {31'd0, finish_flag}, 32'd1);
    check("mis_fault", {30'd0, fault},       32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mis_stk_fin",   {31'd0, finish_flag}, 32'd1);
      check("mis_stk_fault", {30'd0, fault},       32'd1);
      check("mis_stk_req",   {31'd0, imem_req},    32'd0);
    end

    // ---- reset during WAIT, late response ignored ---------------------
    apply_reset(32'h0000_0020);
    reset = 1'b1;
    tick();                                   // REQ
    check("rw_addr", {2'd0, imem_addr}, 32'd8);
    tick();                                   // WAIT
    reset = 1'b0;
    tick();                                   // -> IDLE
    check("rw_iv",    {31'd0, instr_valid}, 32'd0);
    check("rw_addr0", {2'd0, imem_addr},    32'd0);
    check("rw_ipc",   instr_pc,             32'd0);
    check("rw_req",   {31'd0, imem_req},    32'd0);
    reset      = 1'b1;
    imem_valid = 1'b1;                        // late response
    imem_rdata = 32'hDEAD_BEEF;
    tick();                                   // IDLE -> REQ
    imem_valid = 1'b0;
    check("rw_iv2",   {31'd0, instr_valid}, 32'd0);
    check("rw_instr", instr,                32'd0);
    check("rw_req2",  {31'd0, imem_req},    32'd1);
    tick();                                   // WAIT
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();                                   // HOLD
    imem_valid = 1'b0;
    check("rw_re_iv",    {31'd0, instr_valid}, 32'd1);
    check("rw_re_instr", instr,                32'h0000_0013);
    check("rw_re_ipc",   instr_pc,             32'h0000_0020);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
